// File: rtl/branch_resolve.sv
// Purpose: EX-stage branch resolution. It decodes funct3, judges the comparator result, trains a 2-bit BHT and redirects fetch on a mispredict.
// Latency: a resolving branch drives redirect_valid/redirect_pc one cycle later, as a single-cycle pulse. if_pred_taken is combinational.
// Backpressure: stall freezes all state. Define BRANCH_STATS_EN to add the branch_count/mispred_count statistics registers.
module branch_resolve #(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            br_valid,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_target,
  input  logic            br_pred_taken,
  input  logic            stall,
  output logic            sign_select,
  input  logic            equal,
  input  logic            less_than,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] br_idx;
  logic             taken;
  logic             legal;
  logic             resolve;
  logic             upd;
  logic             mispredict;
  logic [XLEN-1:0]  pc_plus4;

  // Fetch PC bits outside the BHT index never influence the lookup.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_idx        = if_pc[IDX_W+1:2];
  assign br_idx        = br_pc[IDX_W+1:2];
  assign if_pred_taken = bht_q[if_idx][1];
  assign sign_select   = br_funct3[1];
  assign pc_plus4      = br_pc + XLEN'(4);

  // Evaluate the branch condition. The reserved encodings 010/011 are not branches.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (br_funct3)
      3'b000:          taken = equal;
      3'b001:          taken = ~equal;
      3'b100, 3'b110:  taken = less_than;
      3'b101, 3'b111:  taken = ~less_than;
      default: begin
        taken = 1'b0;
        legal = 1'b0;
      end
    endcase
  end

  // During the redirect pulse, the branch in EX is on the wrong path and is dropped.
  assign resolve    = br_valid & ~stall & ~redirect_valid_q;
  assign upd        = resolve & legal;
  assign mispredict = taken ^ br_pred_taken;

  // Next-state logic for the redirect and for BHT counter training (saturating).
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    for (int i = 0; i < BHT_ENTRIES; i++) bht_d[i] = bht_q[i];
    if (upd) begin
      redirect_valid_d = mispredict;
      redirect_pc_d    = taken ? br_target : pc_plus4;
      if (taken && bht_q[br_idx] != 2'b11)
        bht_d[br_idx] = bht_q[br_idx] + 2'b01;
      else if (!taken && bht_q[br_idx] != 2'b00)
        bht_d[br_idx] = bht_q[br_idx] - 2'b01;
    end
  end

  // Redirect and BHT state. Counters reset to weak not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  // The statistics count in the same cycle as the BHT update and wrap naturally.
  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (upd) begin
      branch_count_d = branch_count_q + 32'd1;
      if (mispredict) mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign branch_count  = branch_count_q;
  assign mispred_count = mispred_count_q;
`else
  assign branch_count  = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve. The stimulus queues each expected redirect (cycle and pc).
// A negedge monitor matches every redirect pulse against that queue and flags missing or extra pulses.
module tb_branch_resolve;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        br_valid;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        br_pred_taken;
  logic        stall;
  logic        sign_select;
  logic        equal;
  logic        less_than;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  branch_resolve #(.BHT_ENTRIES(64), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .br_valid       (br_valid),
    .br_funct3      (br_funct3),
    .br_pc          (br_pc),
    .br_target      (br_target),
    .br_pred_taken  (br_pred_taken),
    .stall          (stall),
    .sign_select    (sign_select),
    .equal          (equal),
    .less_than      (less_than),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic eq, input logic lt, input logic st);
    br_valid      = 1'b1;
    br_funct3     = f3;
    br_pc         = pc;
    br_target     = tgt;
    br_pred_taken = pred;
    equal         = eq;
    less_than     = lt;
    stall         = st;
  endtask

  task automatic idle();
    br_valid = 1'b0;
    stall    = 1'b0;
    equal    = 1'b0;
    less_than = 1'b0;
  endtask

  task automatic expect_redirect(input logic [31:0] pc);
    exp_t e;
    e.cyc = cyc + 1;
    e.pc  = pc;
    exp_q.push_back(e);
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    chk(name, {31'd0, if_pred_taken}, {31'd0, exp});
  endtask

  task automatic chk_counts(input string name, input logic [31:0] b, input logic [31:0] m);
`ifdef BRANCH_STATS_EN
    chk({name, "_branch"}, branch_count, b);
    chk({name, "_mispred"}, mispred_count, m);
`else
    chk({name, "_branch"}, branch_count, 32'd0);
    chk({name, "_mispred"}, mispred_count, 32'd0);
    if (b == 32'hFFFF_FFFF && m == 32'hFFFF_FFFF) $display("unreachable");
`endif
  endtask

  // Redirect monitor: each pulse must match the oldest queued expectation, in both cycle and pc.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL redirect_missing: got none at cycle %0d expected pc=%h", exp_q[0].cyc, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      if (rst_n && redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL redirect_unexpected: got pc=%h at cycle %0d expected no redirect", redirect_pc, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.pc !== redirect_pc) begin
            errors++;
            $display("FAIL redirect: got pc=%h cycle=%0d expected pc=%h cycle=%0d", redirect_pc, cyc, e.pc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    br_funct3 = 3'b000;
    br_pc = '0;
    br_target = '0;
    br_pred_taken = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk_pred("reset_pred_0x100", 32'h100, 1'b0);
    chk_counts("reset_counts", 32'd0, 32'd0);
    rst_n = 1'b1;
    step();

    // BEQ taken with pred 0: mispredict to target. The lookup in the same cycle sees the old counter value.
    drive(BEQ, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_redirect(32'h80);
    #1;
    chk("beq_sign_select", {31'd0, sign_select}, 32'd0);
    chk_pred("rbw_pred_0x100", 32'h100, 1'b0);
    step(); idle(); step();
    chk_pred("beq_trained_0x100", 32'h100, 1'b1);
    chk_pred("alias_0x200", 32'h200, 1'b1);
    chk_pred("other_idx_0x104", 32'h104, 1'b0);

    // BLTU not taken with pred 1: redirect to pc+4. The counter moves 01->00.
    drive(BLTU, 32'h208, 32'h900, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_redirect(32'h20C);
    #1;
    chk("bltu_sign_select", {31'd0, sign_select}, 32'd1);
    step(); idle(); step();
    chk_pred("bltu_nt_0x208", 32'h208, 1'b0);
    // BLTU taken with pred 0: the counter moves 00->01 and the prediction stays not-taken.
    drive(BLTU, 32'h208, 32'h900, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_redirect(32'h900);
    step(); idle(); step();
    chk_pred("bltu_t_0x208", 32'h208, 1'b0);

    // Correct prediction on the aliased entry: no redirect, and the counter moves 10->11.
    drive(BNE, 32'h200, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); idle(); step();
    // BEQ not taken with pred 1: redirect to 0x104. The counter moves 11->10 and the prediction stays taken.
    drive(BEQ, 32'h100, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_redirect(32'h104);
    step(); idle(); step();
    chk_pred("hyst_0x100", 32'h100, 1'b1);

    // Wrong-path branch during the redirect pulse is ignored.
    drive(BGE, 32'h110, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_redirect(32'h400);
    step();
    drive(BEQ, 32'h10C, 32'h800, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); idle(); step();
    chk_pred("wrongpath_0x10C", 32'h10C, 1'b0);
    chk_pred("bge_trained_0x110", 32'h110, 1'b1);

    // Stall holds the branch in EX. It resolves only once the stall is released.
    drive(BLT, 32'h114, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1);
    step(); step();
    chk_pred("stalled_0x114", 32'h114, 1'b0);
    stall = 1'b0;
    expect_redirect(32'h500);
    step(); idle(); step();
    chk_pred("released_0x114", 32'h114, 1'b1);

    // pc+4 wraps to zero.
    drive(BNE, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_redirect(32'h0);
    step(); idle(); step();
    chk_pred("wrap_idx63", 32'hFFFF_FFFC, 1'b0);

    // Reserved funct3: no redirect, no training, not counted.
    drive(3'b010, 32'h118, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); idle(); step();
    chk_pred("illegal_0x118", 32'h118, 1'b0);
    chk_counts("counts_mid", 32'd8, 32'd7);

    // Asynchronous reset in the middle of a redirect pulse drops the pulse at once.
    drive(BEQ, 32'h11C, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    chk("pulse_valid", {31'd0, redirect_valid}, 32'd1);
    chk("pulse_pc", redirect_pc, 32'h44);
    chk_counts("counts_end", 32'd9, 32'd8);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {31'd0, redirect_valid}, 32'd0);
    chk("midreset_pc", redirect_pc, 32'd0);
    chk_counts("midreset_counts", 32'd0, 32'd0);
    chk_pred("midreset_pred_0x100", 32'h100, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
